// File: rtl/i2c_design.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_design                                                   |
// | Description : I2C master plus 128x8 register-file slave joined by an       |
// |               internal open-drain SDA/SCL bus. The user side issues        |
// |               single-byte write/read transactions to a 7-bit address.      |
// | Ports       : clk   - system clock (rising edge)                           |
// |               rst   - asynchronous active-low reset                        |
// |               newd  - transaction request, sampled in IDLE                 |
// |               wr    - 1 = write, 0 = read (latched at start)               |
// |               wdata - write byte (latched at start)                        |
// |               addr  - 7-bit slave memory address (latched at start)        |
// |               rdata - last byte returned by a successful read              |
// |               done  - one-cycle completion pulse                           |
// | Options     : I2C_ADDR_MATCH_EN - slave answers only addr[6:4]==3'b001,    |
// |               memory shrinks to 16 bytes indexed by addr[3:0].             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_design #(
  parameter int CLK_DIV = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic [6:0] addr,
  output logic [7:0] rdata,
  output logic       done
);

  localparam int c_cw = $clog2(CLK_DIV);
  localparam logic [c_cw-1:0] c_q    = c_cw'(CLK_DIV / 4);
  localparam logic [c_cw-1:0] c_q2   = c_cw'(CLK_DIV / 2);
  localparam logic [c_cw-1:0] c_q3   = c_cw'((CLK_DIV / 4) * 3);
  localparam logic [c_cw-1:0] c_last = c_cw'(CLK_DIV - 1);

`ifdef I2C_ADDR_MATCH_EN
  localparam int c_depth = 16;
  localparam int c_iw    = 4;
`else
  localparam int c_depth = 128;
  localparam int c_iw    = 7;
`endif

  // ---------------------------------------------------------------- bus
  logic w_sda_m, w_scl_m, r_sda_s;
  logic w_sda, w_scl;
  assign w_sda = w_sda_m & r_sda_s;   // open drain: any side pulling low wins
  assign w_scl = w_scl_m;

  // ------------------------------------------------------------- master
  typedef enum logic [3:0] {
    M_IDLE, M_START, M_ADDR, M_AACK, M_WDATA, M_RDATA, M_DACK, M_STOP, M_DONE
  } m_state_t;

  m_state_t          r_state, w_next;
  logic [c_cw-1:0]   r_cnt;
  logic [2:0]        r_bit;
  logic              r_go, r_armed, r_wr, r_nack, r_done;
  logic [7:0]        r_abyte, r_wd, r_rx, r_rdata;
  logic              w_bit_end, w_samp, w_sclh, w_in_byte, w_launch;

  assign w_bit_end = (r_cnt == c_last);
  assign w_samp    = (r_cnt == c_q2);
  assign w_sclh    = (r_cnt >= c_q) && (r_cnt < c_q3);
  assign w_in_byte = (r_state == M_ADDR) || (r_state == M_WDATA) || (r_state == M_RDATA);
  // One idle cycle between the request sample and START; r_go marks it.
  assign w_launch  = (r_state == M_IDLE) && newd && r_armed && !r_go;

  always_comb begin
    w_next  = r_state;
    w_scl_m = 1'b1;
    w_sda_m = 1'b1;
    case (r_state)
      M_IDLE:  if (r_go) w_next = M_START;
      M_START: begin
        // SCL stays high from idle until q3; SDA falls at q2 -> START
        w_scl_m = (r_cnt < c_q3);
        w_sda_m = (r_cnt < c_q2);
        if (w_bit_end) w_next = M_ADDR;
      end
      M_ADDR: begin
        w_scl_m = w_sclh;
        w_sda_m = r_abyte[~r_bit];
        if (w_bit_end && r_bit == 3'd7) w_next = M_AACK;
      end
      M_AACK: begin
        w_scl_m = w_sclh;
        if (w_bit_end) w_next = r_nack ? M_STOP : (r_wr ? M_WDATA : M_RDATA);
      end
      M_WDATA: begin
        w_scl_m = w_sclh;
        w_sda_m = r_wd[~r_bit];
        if (w_bit_end && r_bit == 3'd7) w_next = M_DACK;
      end
      M_RDATA: begin
        w_scl_m = w_sclh;
        if (w_bit_end && r_bit == 3'd7) w_next = M_DACK;
      end
      M_DACK: begin
        // released SDA: slave ACK on writes, master NACK on reads
        w_scl_m = w_sclh;
        if (w_bit_end) w_next = M_STOP;
      end
      M_STOP: begin
        // SCL rises at q1 and stays high; SDA rises at q2 -> STOP
        w_scl_m = (r_cnt >= c_q);
        w_sda_m = (r_cnt >= c_q2);
        if (w_bit_end) w_next = M_DONE;
      end
      M_DONE:  w_next = M_IDLE;
      default: w_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= M_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_go    <= 1'b0;
      r_armed <= 1'b1;
      r_wr    <= 1'b0;
      r_abyte <= '0;
      r_wd    <= '0;
      r_nack  <= 1'b0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == M_DONE);
      r_go    <= w_launch;
      if (r_state == M_IDLE || w_bit_end) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;
      if (!w_in_byte)     r_bit <= '0;
      else if (w_bit_end) r_bit <= r_bit + 1'b1;
      if (w_launch) begin
        r_wr    <= wr;
        r_abyte <= {addr, ~wr};
        r_wd    <= wdata;
      end
      // Disarm after every transaction until newd is seen low in IDLE.
      if (r_state == M_DONE)                 r_armed <= 1'b0;
      else if (r_state == M_IDLE && !newd)   r_armed <= 1'b1;
      if (r_state == M_AACK && w_samp)  r_nack <= w_sda;
      if (r_state == M_RDATA && w_samp) r_rx   <= {r_rx[6:0], w_sda};
      if (r_state == M_DONE && !r_wr && !r_nack) r_rdata <= r_rx;
    end
  end

  assign rdata = r_rdata;
  assign done  = r_done;

  // -------------------------------------------------------------- slave
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WR, S_RD, S_IGN} s_state_t;

  s_state_t         r_sst, w_snext;
  logic             r_scl_d, r_sda_d;
  logic [3:0]       r_sbit;
  logic [7:0]       r_ssr;
  logic [c_iw-1:0]  r_sidx, w_aidx;
  logic [c_cw-1:0]  r_stmr;
  logic [7:0]       r_mem [c_depth];
  logic             w_start, w_stop, w_rise, w_fall, w_avalid, w_sdrv, w_last;

  assign w_start = w_scl && r_scl_d && r_sda_d && !w_sda;
  assign w_stop  = w_scl && r_scl_d && !r_sda_d && w_sda;
  assign w_rise  = w_scl && !r_scl_d;
  assign w_fall  = !w_scl && r_scl_d;
  assign w_last  = (r_sbit == 4'd8);

  always_comb begin
`ifdef I2C_ADDR_MATCH_EN
    w_avalid = (r_ssr[7:5] == 3'b001);
    w_aidx   = r_ssr[4:1];
`else
    w_avalid = 1'b1;
    w_aidx   = r_ssr[7:1];
`endif
  end

  always_comb begin
    w_snext = r_sst;
    w_sdrv  = 1'b1;
    if (w_start)      w_snext = S_ADDR;
    else if (w_stop)  w_snext = S_IDLE;
    else if (w_rise && w_last) begin
      case (r_sst)
        S_ADDR:  w_snext = !w_avalid ? S_IGN : (r_ssr[0] ? S_RD : S_WR);
        S_WR:    w_snext = S_IGN;
        S_RD:    w_snext = S_IGN;
        default: w_snext = r_sst;
      endcase
    end
    // Drive value for the upcoming bit, r_sbit already points at it.
    case (r_sst)
      S_ADDR:  if (w_last)  w_sdrv = !w_avalid;
      S_WR:    if (w_last)  w_sdrv = 1'b0;
      S_RD:    if (!w_last) w_sdrv = r_mem[r_sidx][~r_sbit[2:0]];
      default: w_sdrv = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sst   <= S_IDLE;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
      r_sbit  <= '0;
      r_ssr   <= '0;
      r_sidx  <= '0;
      r_stmr  <= '0;
      r_sda_s <= 1'b1;
      for (int i = 0; i < c_depth; i++) r_mem[i] <= '0;
    end else begin
      r_sst   <= w_snext;
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
      if (w_start || w_stop) begin
        r_sbit  <= '0;
        r_stmr  <= '0;
        r_sda_s <= 1'b1;
      end else begin
        if (w_rise) begin
          r_sbit <= w_last ? 4'd0 : r_sbit + 4'd1;
          if (!w_last && (r_sst == S_ADDR || r_sst == S_WR)) r_ssr <= {r_ssr[6:0], w_sda};
          if (w_last && r_sst == S_ADDR) r_sidx <= w_aidx;
          if (w_last && r_sst == S_WR)   r_mem[r_sidx] <= r_ssr;
        end
        // SCL falls at q3; wait out the rest of the bit so SDA changes in q0.
        if (w_fall)              r_stmr <= c_q - 1'b1;
        else if (r_stmr != '0)   r_stmr <= r_stmr - 1'b1;
        if (r_stmr == c_cw'(1))  r_sda_s <= w_sdrv;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_design.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_design                                                |
// | Description : Directed bench for i2c_design with a passive bus monitor.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_i2c_design;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       newd  = 1'b0;
  logic       wr    = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [6:0] addr  = 7'h00;
  logic [7:0] rdata;
  logic       done;

  int total = 0;
  int bad   = 0;

  i2c_design #(.CLK_DIV(40)) dut (
    .clk   (clk),
    .rst   (rst),
    .newd  (newd),
    .wr    (wr),
    .wdata (wdata),
    .addr  (addr),
    .rdata (rdata),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: START/STOP counts and SDA captured at every SCL rise.
  logic        m_sda_d = 1'b1;
  logic        m_scl_d = 1'b1;
  int          starts  = 0;
  int          stops   = 0;
  int          nrise   = 0;
  logic [31:0] mbits   = '0;

  always @(negedge clk) begin : mon
    logic s, c;
    s = dut.w_sda;
    c = dut.w_scl;
    if (c && m_scl_d && m_sda_d && !s) begin
      starts++;
      nrise = 0;
      mbits = '0;
    end
    if (c && m_scl_d && !m_sda_d && s) stops++;
    if (c && !m_scl_d) begin
      nrise++;
      mbits = {mbits[30:0], s};
    end
    m_sda_d = s;
    m_scl_d = c;
  end

  task automatic xact(input logic w, input logic [6:0] a, input logic [7:0] d,
                      input bit hold, output int cyc, output logic [7:0] rd);
    @(negedge clk); newd = 1'b0;
    @(negedge clk); wr = w; addr = a; wdata = d; newd = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk); cyc++; #1;
      if (cyc == 50) begin wr = ~w; addr = ~a; wdata = ~d; end
      if (done) break;
    end
    check("done_seen", done, 1'b1);
    rd = rdata;
    @(posedge clk); #1;
    check("done_width", done, 1'b0);
    if (!hold) newd = 1'b0;
  endtask

  initial begin
    int cyc, s0, p0, hits;
    logic [7:0] rd;

    // reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_sda", dut.w_sda, 1'b1);
    check("rst_scl", dut.w_scl, 1'b1);

    xact(1'b0, 7'h05, 8'h00, 1'b0, cyc, rd);
    check("rd05_after_rst", rd, 8'h00);

    // write 0x27 to 0x10
    s0 = starts; p0 = stops;
    xact(1'b1, 7'h10, 8'h27, 1'b0, cyc, rd);
    check("wr_latency", cyc, 802);
    check("wr_rdata_kept", rd, 8'h00);
    check("wr_starts", starts - s0, 1);
    check("wr_stops", stops - p0, 1);
    check("wr_nrise", nrise, 19);
    check("wr_addr_byte", mbits[18:11], 8'h20);
    check("wr_addr_ack", mbits[10], 1'b0);
    check("wr_data_byte", mbits[9:2], 8'h27);
    check("wr_data_ack", mbits[1], 1'b0);

    // read it back
    s0 = starts; p0 = stops;
    xact(1'b0, 7'h10, 8'h00, 1'b0, cyc, rd);
    check("rd_latency", cyc, 802);
    check("rd10", rd, 8'h27);
    check("rd_stops", stops - p0, 1);
    check("rd_addr_byte", mbits[18:11], 8'h21);
    check("rd_addr_ack", mbits[10], 1'b0);
    check("rd_bus_data", mbits[9:2], 8'h27);
    check("rd_master_nack", mbits[1], 1'b1);
    check("rd_rdata_port", rdata, 8'h27);

`ifndef I2C_ADDR_MATCH_EN
    // address extremes, last read holds newd high
    xact(1'b1, 7'h00, 8'hA5, 1'b0, cyc, rd);
    xact(1'b1, 7'h7F, 8'h5A, 1'b0, cyc, rd);
    check("wr7f_rdata_kept", rd, 8'h27);
    xact(1'b0, 7'h00, 8'h00, 1'b0, cyc, rd);
    check("rd00", rd, 8'hA5);
    xact(1'b0, 7'h7F, 8'h00, 1'b1, cyc, rd);
    check("rd7f", rd, 8'h5A);
    s0 = starts; hits = 0;
    repeat (1000) begin @(posedge clk); #1; if (done) hits++; end
    check("hold_no_done", hits, 0);
    check("hold_no_start", starts - s0, 0);
    newd = 1'b0;
`endif

    // reset in the middle of WDATA bit 4
    @(negedge clk); newd = 1'b0;
    @(negedge clk); wr = 1'b1; addr = 7'h10; wdata = 8'h00; newd = 1'b1;
    @(posedge clk);
    repeat (566) @(posedge clk);
    #1;
    check("mid_scl_low", dut.w_scl, 1'b0);
    check("mid_sda_low", dut.w_sda, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_sda", dut.w_sda, 1'b1);
    check("mid_rst_scl", dut.w_scl, 1'b1);
    check("mid_rst_rdata", rdata, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; newd = 1'b0;
    hits = 0;
    repeat (1000) begin @(posedge clk); #1; if (done) hits++; end
    check("mid_rst_no_done", hits, 0);
    xact(1'b0, 7'h10, 8'h00, 1'b0, cyc, rd);
    check("rd10_after_rst", rd, 8'h00);

`ifdef I2C_ADDR_MATCH_EN
    // write 0x55 to 0x10, then an unmatched write must be NACKed
    xact(1'b1, 7'h10, 8'h55, 1'b0, cyc, rd);
    s0 = starts; p0 = stops;
    xact(1'b1, 7'h40, 8'h99, 1'b0, cyc, rd);
    check("nack_latency", cyc, 442);
    check("nack_rdata_kept", rd, 8'h00);
    check("nack_nrise", nrise, 10);
    check("nack_addr_byte", mbits[9:2], 8'h80);
    check("nack_bit", mbits[1], 1'b1);
    check("nack_stops", stops - p0, 1);
    xact(1'b0, 7'h10, 8'h00, 1'b0, cyc, rd);
    check("nack_mem_kept", rd, 8'h55);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
